fetch_decode_ctrl: RTL and testbench
====================================

Name: fetch_decode_ctrl

Overview:
Parametrised successor to the processor's PC / instruction-ROM / IR / decode control path.
- Fetches instructions over a variable-latency req/ack memory handshake.
- Holds the fetched word in an IR and presents registered decode controls to the datapath under a valid/ready handshake.
- Handles jumps, halt/restart and downstream stalls through an explicit FSM.
- Sits between the instruction memory and the register-file/ALU datapath.

Parameters:
ADDR_W, 8, PC / instruction-address width
INSTR_W, 16, instruction width; must be >= OP_W+3*REG_W and >= OP_W+ADDR_W
OP_W, 4, opcode width
REG_W, 3, register-specifier width
IMM_W, 6, immediate width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  leave IDLE/HALTED and begin fetching
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address (= PC)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  INSTR_W  fetched instruction
ex_ready  in  1  datapath accepts the current decode
dec_valid  out  1  decode outputs valid
instr  out  INSTR_W  IR contents
instr_pc  out  ADDR_W  PC of the instruction in the IR
opcode  out  OP_W  IR[INSTR_W-1 -: OP_W]
rd  out  REG_W  next REG_W bits below opcode
rs1  out  REG_W  next REG_W bits below rd
rs2  out  REG_W  next REG_W bits below rs1
imm  out  IMM_W  IR[IMM_W-1:0]
jump_addr  out  ADDR_W  IR[ADDR_W-1:0]
pc_select  out  1  jump taken
src2_select  out  1  1 = immediate operand, 0 = rs2
alu_out_select  out  1  1 = memory result, 0 = ALU result
regwrite  out  1  register-file write enable
halted  out  1  FSM in HALTED

Behaviour:
- Reset (rst high at a clk edge, any state):
  - FSM = IDLE, PC = RESET_PC, IR = 0, instr_pc = 0.
  - All outputs 0; the field outputs are 0 because IR = 0.
  - Any in-flight fetch is abandoned; a late imem_ack is ignored.
- Reset has priority over every other input.
- States IDLE, FETCH, DECODE, HALTED.
- IDLE:
  - All controls 0.
  - start=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - Holds until imem_ack=1; any number of wait cycles is legal.
  - On the ack cycle: IR <= imem_rdata, instr_pc <= PC, go to DECODE.
  - Minimum fetch-to-dec_valid latency: 1 cycle after the ack edge.
- DECODE:
  - dec_valid=1; all decode outputs are combinational from the IR and stable while dec_valid=1.
  - Stall: dec_valid & !ex_ready -> stay in DECODE, outputs held.
  - Retire: dec_valid & ex_ready -> retire; see the PC and next-state rules below.
- Decode table (opcode value, for OP_W=4; for wider OP_W, compare the top 4 opcode bits):
  - 0x0-0x7 R-type: regwrite=1, src2_select=0, alu_out_select=0.
  - 0x8-0xB I-type: regwrite=1, src2_select=1, alu_out_select=0.
  - 0xC LOAD: regwrite=1, src2_select=1, alu_out_select=1.
  - 0xD STORE: regwrite=0, src2_select=1.
  - 0xE HALT: all controls 0.
  - 0xF JMP: pc_select=1, regwrite=0.
  - Controls not listed for a row are 0.
  - Every control is gated by dec_valid: 0 outside DECODE.
- PC update on retire:
  - JMP: PC <= jump_addr.
  - Otherwise: PC <= PC+1, modulo 2^ADDR_W (all-ones wraps to 0).
- Next state on retire:
  - HALT -> HALTED, with PC <= PC+1.
  - Otherwise -> FETCH.
- HALTED:
  - halted=1, no fetch.
  - start=1 -> FETCH at the current PC.
- start is ignored in FETCH and DECODE.
- imem_ack outside FETCH is ignored.
- Any unused or illegal state recovers to IDLE.

Optional Feature:
PERF_CNT_EN
- Defined: adds output retired_cnt, 16 bits.
  - Increments on each retire (dec_valid & ex_ready).
  - Saturates at 0xFFFF.
  - Cleared by rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset and start:
  - rst for 2 cycles, then start=1 with 0-wait ack returning 0x1234 at addr 0.
  - Expect imem_addr=0, dec_valid 1 cycle after the ack, opcode=1, rd=1, rs1=0, rs2=6, regwrite=1, src2_select=0.
  - After retire, next imem_addr=1.
- Wait states and stall:
  - imem_ack delayed 3 cycles: imem_req is held 4 cycles with a stable address.
  - ex_ready=0 for 2 cycles in DECODE: outputs are held, PC is unchanged.
- Jump:
  - At PC=5, fetch 0xF0A7.
  - Expect pc_select=1, jump_addr=0xA7; the next fetch address is 0xA7.
- Wrap and halt:
  - RESET_PC=0xFF, fetch 0x8003: imm=3, src2_select=1; the next address is 0x00.
  - At PC=0x00, fetch 0xE000: halted=1 and no imem_req.
  - Pulse start: the next fetch address is 0x01.
- Reset mid-operation:
  - Assert rst during FETCH with the ack pending: IDLE, PC=RESET_PC, outputs 0.
  - An ack in the following cycle is ignored.
- With PERF_CNT_EN: 3 retires -> retired_cnt=3; rst -> 0.

Source files
------------

// File: rtl/fetch_decode_ctrl.sv
// rtl/fetch_decode_ctrl.sv - PC / fetch / IR / decode control path; optional retire counter under PERF_CNT_EN
module fetch_decode_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int OP_W     = 4,
  parameter int REG_W    = 3,
  parameter int IMM_W    = 6,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               ex_ready,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [OP_W-1:0]    opcode,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   rs1,
  output logic [REG_W-1:0]   rs2,
  output logic [IMM_W-1:0]   imm,
  output logic [ADDR_W-1:0]  jump_addr,
  output logic               pc_select,
  output logic               src2_select,
  output logic               alu_out_select,
  output logic               regwrite,
  output logic               halted
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]        retired_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   pc_next;
  logic [INSTR_W-1:0]  ir;
  logic [INSTR_W-1:0]  ir_next;
  logic [ADDR_W-1:0]   ipc;
  logic [ADDR_W-1:0]   ipc_next;

  // Opcode class is taken from the top four opcode bits so wider opcodes keep the same table.
  logic [3:0]          op_class;
  logic                is_rtype;
  logic                is_itype;
  logic                is_load;
  logic                is_store;
  logic                is_halt;
  logic                is_jmp;
  logic                retire;

  // Instruction fields are plain slices of the IR; IR is zero after reset so these read 0 too.
  always_comb begin
    instr     = ir;
    instr_pc  = ipc;
    opcode    = ir[INSTR_W-1 -: OP_W];
    rd        = ir[INSTR_W-OP_W-1 -: REG_W];
    rs1       = ir[INSTR_W-OP_W-REG_W-1 -: REG_W];
    rs2       = ir[INSTR_W-OP_W-2*REG_W-1 -: REG_W];
    imm       = ir[IMM_W-1:0];
    jump_addr = ir[ADDR_W-1:0];
    op_class  = opcode[OP_W-1 -: 4];
    is_rtype  = (op_class < 4'h8);
    is_itype  = (op_class >= 4'h8) && (op_class <= 4'hB);
    is_load   = (op_class == 4'hC);
    is_store  = (op_class == 4'hD);
    is_halt   = (op_class == 4'hE);
    is_jmp    = (op_class == 4'hF);
  end

  // Next-state, PC/IR update and all handshake/control outputs; controls are gated by DECODE.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    ir_next        = ir;
    ipc_next       = ipc;
    imem_req       = 1'b0;
    imem_addr      = '0;
    dec_valid      = 1'b0;
    halted         = 1'b0;
    pc_select      = 1'b0;
    src2_select    = 1'b0;
    alu_out_select = 1'b0;
    regwrite       = 1'b0;
    retire         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        if (imem_ack) begin
          ir_next    = imem_rdata;
          ipc_next   = pc;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        dec_valid      = 1'b1;
        regwrite       = is_rtype | is_itype | is_load;
        src2_select    = is_itype | is_load | is_store;
        alu_out_select = is_load;
        pc_select      = is_jmp;
        retire         = ex_ready;
        if (ex_ready) begin
          pc_next    = is_jmp ? jump_addr : pc + PC_ONE;
          state_next = is_halt ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: begin
        halted = 1'b1;
        if (start) begin
          state_next = S_FETCH;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, PC and IR registers; reset abandons any in-flight fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= PC_INIT;
      ir    <= '0;
      ipc   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
      ipc   <= ipc_next;
    end
  end

`ifdef PERF_CNT_EN
  // Saturating count of retired instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if (retire && (retired_cnt != 16'hFFFF)) begin
      retired_cnt <= retired_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// tb/tb_fetch_decode_ctrl.sv - randomized scoreboard bench for fetch_decode_ctrl
module tb_fetch_decode_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        ex_ready;
  logic        dec_valid;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic [3:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [5:0]  imm;
  logic [7:0]  jump_addr;
  logic        pc_select;
  logic        src2_select;
  logic        alu_out_select;
  logic        regwrite;
  logic        halted;
`ifdef PERF_CNT_EN
  logic [15:0] retired_cnt;
`endif

  fetch_decode_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ex_ready(ex_ready), .dec_valid(dec_valid), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .jump_addr(jump_addr),
    .pc_select(pc_select), .src2_select(src2_select), .alu_out_select(alu_out_select),
    .regwrite(regwrite), .halted(halted)
`ifdef PERF_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  typedef struct {
    logic [15:0] w;
    logic [7:0]  pc;
  } rec_t;

  rec_t        q[$];
  logic [15:0] mem [256];
  logic [7:0]  model_pc;
  logic [7:0]  req_addr;
  int          req_cnt;
  int          lat;
  int          n_checks;
  int          n_pass;
  int          n_ret;
  bit          exp_halt;
  bit          start_en;
  bit          mem_en;
  bit          late_ack;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected {pc_select, src2_select, alu_out_select, regwrite} from the opcode table.
  function automatic logic [3:0] exp_ctrl(input logic [15:0] w);
    int op;
    op = int'(w >> 12);
    if (op < 8)        return 4'b0001;
    else if (op < 12)  return 4'b0101;
    else if (op == 12) return 4'b0111;
    else if (op == 13) return 4'b0100;
    else if (op == 14) return 4'b0000;
    else               return 4'b1000;
  endfunction

  function automatic logic [31:0] exp_fields(input logic [15:0] w);
    int op, f_rd, f_rs1, f_rs2, f_imm, f_ja;
    op    = int'(w) / 4096;
    f_rd  = (int'(w) / 512) % 8;
    f_rs1 = (int'(w) / 64) % 8;
    f_rs2 = (int'(w) / 8) % 8;
    f_imm = int'(w) % 64;
    f_ja  = int'(w) % 256;
    return 32'(((((op * 8 + f_rd) * 8 + f_rs1) * 8 + f_rs2) * 64 + f_imm) * 256 + f_ja);
  endfunction

  // Driver and memory model: inputs change 1 time unit after the clock edge.
  initial begin
    ex_ready   = 1'b0;
    start      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    req_cnt    = 0;
    lat        = 0;
    model_pc   = 8'h00;
    req_addr   = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      ex_ready = ($urandom % 4) != 0;
      start    = start_en && (($urandom % 4) == 0);
      if (rst) begin
        req_cnt  = 0;
        model_pc = 8'h00;
        q.delete();
        imem_ack = 1'b0;
      end else if (imem_req) begin
        if (req_cnt == 0) begin
          lat      = int'($urandom % 4);
          req_addr = imem_addr;
          chk("fetch_addr", 32'(imem_addr), 32'(model_pc));
        end else begin
          chk("fetch_addr_stable", 32'(imem_addr), 32'(req_addr));
        end
        if (mem_en && req_cnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
          q.push_back('{w: imem_rdata, pc: imem_addr});
          if ((imem_rdata >> 12) == 16'd15) model_pc = imem_rdata[7:0];
          else model_pc = 8'(model_pc + 8'd1);
          req_cnt = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 16'($urandom);
          req_cnt++;
        end
      end else begin
        if (req_cnt != 0) chk("req_held_until_ack", 32'(imem_req), 32'd1);
        req_cnt    = 0;
        imem_ack   = late_ack || (($urandom % 4) == 0);
        imem_rdata = 16'($urandom);
      end
    end
  end

  // Monitor: compares the decode outputs against the scoreboard head whenever dec_valid is high.
  initial begin
    rec_t r;
    exp_halt = 1'b0;
    n_ret    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_halt = 1'b0;
        n_ret    = 0;
      end else begin
        if (exp_halt) begin
          chk("halted_after_halt", 32'(halted), 32'd1);
          chk("no_req_when_halted", 32'(imem_req), 32'd0);
          exp_halt = 1'b0;
        end
        if (dec_valid) begin
          chk("scoreboard_nonempty", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            r = q[0];
            chk("instr", 32'(instr), 32'(r.w));
            chk("instr_pc", 32'(instr_pc), 32'(r.pc));
            chk("fields", {5'd0, opcode, rd, rs1, rs2, imm, jump_addr}, exp_fields(r.w));
            chk("controls", 32'({pc_select, src2_select, alu_out_select, regwrite}), 32'(exp_ctrl(r.w)));
            if (ex_ready) begin
              void'(q.pop_front());
              n_ret++;
              if ((r.w >> 12) == 16'd14) exp_halt = 1'b1;
            end
          end
        end else begin
          chk("controls_gated", 32'({pc_select, src2_select, alu_out_select, regwrite}), 32'd0);
        end
      end
    end
  end

  initial begin
    bit got;
    rst      = 1'b1;
    start_en = 1'b0;
    mem_en   = 1'b1;
    late_ack = 1'b0;
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'hF005;
    mem[8'h05] = 16'hF0A7;
    mem[8'hA7] = 16'hF0FF;
    mem[8'hFF] = 16'h8003;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    @(posedge clk);
    #2;
    rst      = 1'b0;
    start_en = 1'b1;

    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (dec_valid) got = 1'b1;
    end
    chk("first_decode_seen", 32'(got), 32'd1);
    if (got) begin
      chk("first_instr", 32'(instr), 32'h1234);
      chk("first_opcode", 32'(opcode), 32'd1);
      chk("first_rd", 32'(rd), 32'd1);
      chk("first_rs1", 32'(rs1), 32'd0);
      chk("first_rs2", 32'(rs2), 32'd6);
      chk("first_regwrite", 32'(regwrite), 32'd1);
      chk("first_src2_select", 32'(src2_select), 32'd0);
    end
    mem[8'h00] = 16'hE000;

    repeat (400) @(posedge clk);
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    repeat (3000) @(posedge clk);

    #2;
    mem_en = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (imem_req) got = 1'b1;
    end
    chk("fetch_pending_before_rst", 32'(got), 32'd1);
    @(posedge clk);
    #2;
    rst      = 1'b1;
    start_en = 1'b0;
    @(posedge clk);
    #2;
    rst      = 1'b0;
    late_ack = 1'b1;
    @(negedge clk);
    chk("midrst_imem_req", 32'(imem_req), 32'd0);
    chk("midrst_dec_valid", 32'(dec_valid), 32'd0);
    chk("midrst_instr", 32'(instr), 32'd0);
    chk("midrst_instr_pc", 32'(instr_pc), 32'd0);
    chk("midrst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    chk("late_ack_ignored_req", 32'(imem_req), 32'd0);
    chk("late_ack_ignored_valid", 32'(dec_valid), 32'd0);
    chk("late_ack_ignored_instr", 32'(instr), 32'd0);
    @(posedge clk);
    #2;
    late_ack = 1'b0;
    mem_en   = 1'b1;
    start_en = 1'b1;
    repeat (400) @(posedge clk);

`ifdef PERF_CNT_EN
    @(negedge clk);
    chk("retired_cnt", 32'(retired_cnt), 32'((n_ret > 65535) ? 65535 : n_ret));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
